// File: rtl/store_buffer_pkg.sv
// Shared types for the post-commit store buffer.
// Entry layout, drain FSM states and a byte-lane helper.
package store_buffer_pkg;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef struct packed {
    logic           valid;
    logic [29:0]    addr;
    rv32i_word      data;
    rv32i_mem_wmask mask;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE,
    SB_WRITE
  } sb_state_t;

  function automatic rv32i_word lane_mask(rv32i_mem_wmask m);
    rv32i_word r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load-probe and memory-write signals of the store buffer.
// slave is the buffer side, master the pipeline/memory side.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic           st_valid;
  logic [31:0]    st_addr;
  rv32i_word      st_wdata;
  rv32i_mem_wmask st_wmask;
  logic           st_ready;
  logic           ld_valid;
  logic [31:0]    ld_addr;
  rv32i_mem_wmask ld_rmask;
  logic           ld_hit;
  rv32i_word      ld_data;
  logic           ld_stall;
  logic           mem_write;
  logic [31:0]    mem_address;
  rv32i_word      mem_wdata;
  rv32i_mem_wmask mem_byte_enable;
  logic           mem_resp;
  logic           empty;

  modport slave (
    input  st_valid, st_addr, st_wdata, st_wmask,
    input  ld_valid, ld_addr, ld_rmask, mem_resp,
    output st_ready, ld_hit, ld_data, ld_stall,
    output mem_write, mem_address, mem_wdata,
    output mem_byte_enable, empty
  );

  modport master (
    output st_valid, st_addr, st_wdata, st_wmask,
    output ld_valid, ld_addr, ld_rmask, mem_resp,
    input  st_ready, ld_hit, ld_data, ld_stall,
    input  mem_write, mem_address, mem_wdata,
    input  mem_byte_enable, empty
  );
endinterface

// File: rtl/store_buffer_fwd.sv
// Youngest-match search over buffered stores for a probing load.
// Valid entries are contiguous from head, so the last hit wins.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t [DEPTH-1:0]     ents,
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic                      ld_valid,
  input  logic [29:0]               ld_word,
  input  rv32i_mem_wmask            ld_rmask,
  output logic                      ld_hit,
  output logic                      ld_stall,
  output rv32i_word                 ld_data
);
  localparam int PW = $clog2(DEPTH);

  logic          found;
  logic [PW-1:0] y;
  sb_entry_t     hit_e;

  // scan oldest to youngest, keeping the last matching slot
  always_comb begin
    found = 1'b0;
    y     = '0;
    for (int k = 0; k < DEPTH; k++) begin : scan
      logic [PW-1:0] idx;
      idx = head + PW'(k);
      if (ld_valid && ents[idx].valid &&
          ents[idx].addr == ld_word) begin
        found = 1'b1;
        y     = idx;
      end
    end
  end

  assign hit_e    = ents[y];
  assign ld_hit   = found &&
                    ((hit_e.mask & ld_rmask) == ld_rmask);
  assign ld_stall = found && !ld_hit;
  assign ld_data  = found ?
                    (hit_e.data & lane_mask(hit_e.mask)) : '0;

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: FIFO of stores drained in order,
// with same-word coalescing and load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] ents;
  logic [PW-1:0] head, tail, yi;
  logic [CW-1:0] count, count_nx;
  sb_state_t     state, state_nx;
  logic          full, coal, push, pop;
  rv32i_word     st_lanes, merged;
  logic          addr_unused;

  assign yi       = tail - PW'(1);
  assign full     = count == CW'(DEPTH);
  assign coal     = bus.st_valid && count != '0 &&
                    ents[yi].addr == bus.st_addr[31:2] &&
                    (count > CW'(1) || state == SB_IDLE);
  assign push     = bus.st_valid && !full && !coal;
  assign pop      = state == SB_WRITE && bus.mem_resp;
  assign count_nx = count + CW'(push) - CW'(pop);

  assign st_lanes = lane_mask(bus.st_wmask);
  assign merged   = (ents[yi].data & ~st_lanes) |
                    (bus.st_wdata & st_lanes);

  assign bus.st_ready        = coal || !full;
  assign bus.empty           = count == '0;
  assign bus.mem_write       = state == SB_WRITE;
  assign bus.mem_address     = {ents[head].addr, 2'b00};
  assign bus.mem_wdata       = ents[head].data;
  assign bus.mem_byte_enable = ents[head].mask;

  assign addr_unused = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  // entry array, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ents  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        ents[head].valid <= 1'b0;
        head <= head + PW'(1);
      end
      if (push) begin
        ents[tail] <= '{valid: 1'b1,
                        addr:  bus.st_addr[31:2],
                        data:  bus.st_wdata,
                        mask:  bus.st_wmask};
        tail <= tail + PW'(1);
      end else if (coal) begin
        ents[yi].data <= merged;
        ents[yi].mask <= ents[yi].mask | bus.st_wmask;
      end
      count <= count_nx;
    end
  end

  // drain FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SB_IDLE;
    else     state <= state_nx;
  end

  // drain FSM next state
  always_comb begin
    state_nx = state;
    unique case (state)
      SB_IDLE:  if (count != '0) state_nx = SB_WRITE;
      SB_WRITE: if (pop && count_nx == '0) state_nx = SB_IDLE;
    endcase
  end

  store_buffer_fwd #(.DEPTH(DEPTH)) u_fwd (
    .ents     (ents),
    .head     (head),
    .ld_valid (bus.ld_valid),
    .ld_word  (bus.ld_addr[31:2]),
    .ld_rmask (bus.ld_rmask),
    .ld_hit   (bus.ld_hit),
    .ld_stall (bus.ld_stall),
    .ld_data  (bus.ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed corner cases,
// a forwarding vector table and random traffic against a queue model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  store_buffer_if sb ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  typedef struct {
    logic        lv;
    logic [31:0] la;
    logic [3:0]  rm;
    logic        hit;
    logic        stall;
    logic [31:0] data;
  } fv_t;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ment_t;

  fv_t   tbl [8];
  ment_t q [$];
  bit    infl;

  function automatic logic [31:0] bm(logic [3:0] m);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++)
      if (m[i]) r = r | (32'hFF << (8 * i));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    sb.st_valid = 0; sb.st_addr = 0; sb.st_wdata = 0;
    sb.st_wmask = 0; sb.ld_valid = 0; sb.ld_addr = 0;
    sb.ld_rmask = 0; sb.mem_resp = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m);
    bit done = 0;
    sb.st_valid = 1; sb.st_addr = a; sb.st_wdata = d; sb.st_wmask = m;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (sb.st_ready) done = 1;
      tick();
    end
    sb.st_valid = 0;
    chk("push_accept", 32'(done), 32'd1);
  endtask

  task automatic wait_mw();
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (sb.mem_write) seen = 1;
      else tick();
    end
    chk("mem_write_seen", 32'(seen), 32'd1);
  endtask

  task automatic drain_one(input logic [31:0] ea, input logic [31:0] ed,
                           input logic [3:0] ebe);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      #1;
      if (sb.mem_write) begin
        chk("drain_addr", sb.mem_address, ea);
        chk("drain_be", 32'(sb.mem_byte_enable), 32'(ebe));
        chk("drain_data", sb.mem_wdata & bm(ebe), ed & bm(ebe));
        sb.mem_resp = 1;
        got = 1;
      end
      tick();
      sb.mem_resp = 0;
    end
    chk("drain_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h300, 4'hF, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[1] = '{1'b1, 32'h302, 4'hC, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[2] = '{1'b1, 32'h301, 4'h2, 1'b1, 1'b0, 32'hCAFEF00D};
    tbl[3] = '{1'b1, 32'h304, 4'hF, 1'b0, 1'b1, 32'h000000AB};
    tbl[4] = '{1'b1, 32'h304, 4'h1, 1'b1, 1'b0, 32'h000000AB};
    tbl[5] = '{1'b1, 32'h308, 4'hF, 1'b0, 1'b0, 32'h00000000};
    tbl[6] = '{1'b1, 32'h400, 4'hF, 1'b1, 1'b0, 32'h00000002};
    tbl[7] = '{1'b0, 32'h300, 4'hF, 1'b0, 1'b0, 32'h00000000};

    idle_in();
    @(negedge clk);
    do_reset();

    // reset state
    sb.ld_valid = 1; sb.ld_addr = 32'h0; sb.ld_rmask = 4'hF;
    #1;
    chk("rst_ready", 32'(sb.st_ready), 32'd1);
    chk("rst_empty", 32'(sb.empty), 32'd1);
    chk("rst_mw", 32'(sb.mem_write), 32'd0);
    chk("rst_hit", 32'(sb.ld_hit), 32'd0);
    chk("rst_stall", 32'(sb.ld_stall), 32'd0);
    chk("rst_ldata", sb.ld_data, 32'd0);
    sb.ld_valid = 0;
    tick();

    // single store
    sb.st_valid = 1; sb.st_addr = 32'h100;
    sb.st_wdata = 32'hDEADBEEF; sb.st_wmask = 4'hF;
    #1 chk("single_ready", 32'(sb.st_ready), 32'd1);
    tick();
    sb.st_valid = 0;
    #1 chk("single_notempty", 32'(sb.empty), 32'd0);
    tick();
    #1;
    chk("single_mw", 32'(sb.mem_write), 32'd1);
    chk("single_addr", sb.mem_address, 32'h100);
    chk("single_data", sb.mem_wdata, 32'hDEADBEEF);
    chk("single_be", 32'(sb.mem_byte_enable), 32'hF);
    tick();
    tick();
    #1;
    chk("single_hold_mw", 32'(sb.mem_write), 32'd1);
    chk("single_hold_addr", sb.mem_address, 32'h100);
    sb.mem_resp = 1;
    tick();
    sb.mem_resp = 0;
    #1 chk("single_empty", 32'(sb.empty), 32'd1);
    tick();
    #1 chk("single_idle", 32'(sb.mem_write), 32'd0);

    // fill past capacity
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      push(32'h600 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    sb.st_valid = 1; sb.st_addr = 32'h610;
    sb.st_wdata = 32'hA4; sb.st_wmask = 4'hF;
    #1 chk("fill_full", 32'(sb.st_ready), 32'd0);
    tick();
    #1 chk("fill_full2", 32'(sb.st_ready), 32'd0);
    sb.mem_resp = 1;
    #1 chk("fill_no_resp_path", 32'(sb.st_ready), 32'd0);
    tick();
    sb.mem_resp = 0;
    #1 chk("fill_freed", 32'(sb.st_ready), 32'd1);
    tick();
    sb.st_valid = 0;
    for (int i = 1; i <= DEPTH; i++)
      drain_one(32'h600 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    #1 chk("fill_empty", 32'(sb.empty), 32'd1);

    // coalesce behind a draining entry
    do_reset();
    push(32'h500, 32'h55555555, 4'hF);
    wait_mw();
    @(negedge clk);
    push(32'h203, 32'h11000000, 4'h8);
    push(32'h200, 32'h00000022, 4'h1);
    sb.ld_valid = 1; sb.ld_addr = 32'h200; sb.ld_rmask = 4'h9;
    #1;
    chk("coal_hit", 32'(sb.ld_hit), 32'd1);
    chk("coal_ldata", sb.ld_data, 32'h11000022);
    sb.ld_valid = 0;
    drain_one(32'h500, 32'h55555555, 4'hF);
    drain_one(32'h200, 32'h11000022, 4'h9);
    #1 chk("coal_empty", 32'(sb.empty), 32'd1);

    // youngest wins over the in-flight head
    do_reset();
    push(32'h400, 32'd1, 4'hF);
    wait_mw();
    @(negedge clk);
    push(32'h400, 32'd2, 4'hF);
    sb.ld_valid = 1; sb.ld_addr = 32'h400; sb.ld_rmask = 4'hF;
    #1;
    chk("young_hit", 32'(sb.ld_hit), 32'd1);
    chk("young_data", sb.ld_data, 32'd2);
    sb.ld_valid = 0;
    drain_one(32'h400, 32'd1, 4'hF);
    drain_one(32'h400, 32'd2, 4'hF);

    // forwarding vector table
    do_reset();
    push(32'h300, 32'hCAFEF00D, 4'hF);
    push(32'h304, 32'h000000AB, 4'h1);
    push(32'h400, 32'd1, 4'hF);
    push(32'h400, 32'd2, 4'hF);
    for (int i = 0; i < 8; i++) begin
      sb.ld_valid = tbl[i].lv;
      sb.ld_addr  = tbl[i].la;
      sb.ld_rmask = tbl[i].rm;
      #1;
      chk($sformatf("fwd%0d_hit", i), 32'(sb.ld_hit), 32'(tbl[i].hit));
      chk($sformatf("fwd%0d_stall", i), 32'(sb.ld_stall),
          32'(tbl[i].stall));
      chk($sformatf("fwd%0d_data", i), sb.ld_data, tbl[i].data);
      tick();
    end
    sb.ld_valid = 1; sb.ld_addr = 32'h304; sb.ld_rmask = 4'hF;
    #1 chk("stall_before", 32'(sb.ld_stall), 32'd1);
    drain_one(32'h300, 32'hCAFEF00D, 4'hF);
    #1 chk("stall_inflight", 32'(sb.ld_stall), 32'd1);
    drain_one(32'h304, 32'h000000AB, 4'h1);
    #1;
    chk("stall_gone", 32'(sb.ld_stall), 32'd0);
    chk("stall_gone_hit", 32'(sb.ld_hit), 32'd0);
    sb.ld_valid = 0;
    drain_one(32'h400, 32'd2, 4'hF);

    // reset in the middle of a drain
    do_reset();
    push(32'h700, 32'd7, 4'hF);
    push(32'h704, 32'd8, 4'hF);
    push(32'h708, 32'd9, 4'hF);
    wait_mw();
    #1 rst = 1'b1;
    #1;
    chk("rmid_mw", 32'(sb.mem_write), 32'd0);
    chk("rmid_empty", 32'(sb.empty), 32'd1);
    chk("rmid_ready", 32'(sb.st_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    sb.mem_resp = 1;
    tick();
    sb.mem_resp = 0;
    tick();
    #1;
    chk("rmid_after_mw", 32'(sb.mem_write), 32'd0);
    chk("rmid_after_empty", 32'(sb.empty), 32'd1);

    // random traffic against the queue model
    do_reset();
    q.delete();
    infl = 0;
    for (int c = 0; c < 1500; c++) begin
      bit          coal, full, pop, acc, found;
      int          n, y;
      logic [31:0] ldd;
      sb.st_valid = 1'($urandom_range(0, 1));
      sb.st_addr  = 32'h100 + 32'(4 * $urandom_range(0, 2)) +
                    32'($urandom_range(0, 3));
      sb.st_wdata = $urandom;
      sb.st_wmask = 4'($urandom_range(1, 15));
      sb.ld_valid = 1'($urandom_range(0, 1));
      sb.ld_addr  = 32'h100 + 32'(4 * $urandom_range(0, 3)) +
                    32'($urandom_range(0, 3));
      sb.ld_rmask = 4'($urandom_range(1, 15));
      sb.mem_resp = ($urandom_range(0, 99) < 40);

      n     = q.size();
      full  = (n == DEPTH);
      coal  = sb.st_valid && n != 0 &&
              q[n-1].a == sb.st_addr[31:2] && !(n == 1 && infl);
      found = 0;
      y     = 0;
      if (sb.ld_valid)
        for (int j = n - 1; j >= 0 && !found; j--)
          if (q[j].a == sb.ld_addr[31:2]) begin
            found = 1;
            y = j;
          end
      ldd = found ? (q[y].d & bm(q[y].m)) : 32'h0;

      #1;
      chk("rnd_ready", 32'(sb.st_ready), 32'(!full || coal));
      chk("rnd_empty", 32'(sb.empty), 32'(n == 0));
      chk("rnd_mw", 32'(sb.mem_write), 32'(infl));
      if (infl) begin
        chk("rnd_maddr", sb.mem_address, {q[0].a, 2'b00});
        chk("rnd_mbe", 32'(sb.mem_byte_enable), 32'(q[0].m));
        chk("rnd_mdata", sb.mem_wdata & bm(q[0].m),
            q[0].d & bm(q[0].m));
      end
      chk("rnd_hit", 32'(sb.ld_hit),
          32'(found && ((q[y].m & sb.ld_rmask) == sb.ld_rmask)));
      chk("rnd_stall", 32'(sb.ld_stall),
          32'(found && ((q[y].m & sb.ld_rmask) != sb.ld_rmask)));
      chk("rnd_ldata", sb.ld_data, ldd);

      pop = infl && sb.mem_resp;
      acc = sb.st_valid && (!full || coal);
      if (coal) begin
        q[n-1].d = (q[n-1].d & ~bm(sb.st_wmask)) |
                   (sb.st_wdata & bm(sb.st_wmask));
        q[n-1].m = q[n-1].m | sb.st_wmask;
      end
      if (pop) void'(q.pop_front());
      if (acc && !coal)
        q.push_back('{sb.st_addr[31:2], sb.st_wdata, sb.st_wmask});
      if (infl) infl = pop ? (q.size() != 0) : 1'b1;
      else      infl = (n != 0);
      tick();
    end

    idle_in();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
